ncl_counter_sequencer: RTL

//  Clocked supervisor for the clockless dual-rail NCL counter chain (DIGITS ring digits, carry rippled).

---
 rtl/ncl_seq_pkg.sv | 17 +
 rtl/dr_sync_classify.sv | 65 ++++++
 rtl/ncl_counter_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ncl_seq_pkg.sv
// Shared types for the NCL counter-chain supervisor: FSM states and dual-rail code points.
package ncl_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, RELEASE, WAIT_DATA, WAIT_NULL, DONE, ERROR
  } seq_state_t;

  localparam logic [1:0] NULL_C = 2'b00;
  localparam logic [1:0] D0_C   = 2'b01;
  localparam logic [1:0] D1_C   = 2'b10;
  localparam logic [1:0] ILL_C  = 2'b11;

  function automatic logic is_data(input logic [1:0] code);
    return (code == D0_C) || (code == D1_C);
  endfunction

endpackage

// File: rtl/dr_sync_classify.sv
// Synchronizes every dual-rail pair of the chain (sums + top carry) and classifies the wavefront.
// all_data / all_null only assert after the condition has held two consecutive clocks.
module dr_sync_classify
  import ncl_seq_pkg::*;
#(
  parameter int DIGITS      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                init,
  input  logic [2*DIGITS-1:0] sum,
  input  logic [1:0]          carry_top,
  output logic                all_data,
  output logic                all_null,
  output logic                illegal,
  output logic [DIGITS-1:0]   value,
  output logic                carry1
);
  localparam int NR = 2 * (DIGITS + 1);

  logic [SYNC_STAGES-1:0][NR-1:0] sync_q, sync_d;
  logic [NR-1:0] rails;
  logic data_now, null_now;
  logic data_prev_q, data_prev_d, null_prev_q, null_prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {carry_top, sum};
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  assign rails = sync_q[SYNC_STAGES-1];

  always_comb begin
    data_now = 1'b1;
    null_now = 1'b1;
    illegal  = 1'b0;
    value    = '0;
    for (int i = 0; i <= DIGITS; i++) begin
      if (rails[2*i +: 2] == ILL_C)  illegal  = 1'b1;
      if (!is_data(rails[2*i +: 2])) data_now = 1'b0;
      if (rails[2*i +: 2] != NULL_C) null_now = 1'b0;
    end
    for (int i = 0; i < DIGITS; i++) value[i] = rails[2*i+1];
  end

  assign carry1      = rails[NR-1];
  assign data_prev_d = data_now;
  assign null_prev_d = null_now;
  assign all_data    = data_now & data_prev_q;
  assign all_null    = null_now & null_prev_q;

  always_ff @(posedge clk) begin
    if (init) begin
      sync_q      <= '0;
      data_prev_q <= 1'b0;
      null_prev_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      data_prev_q <= data_prev_d;
      null_prev_q <= null_prev_d;
    end
  end

endmodule

// File: rtl/ncl_counter_sequencer.sv
// Clocked supervisor for the dual-rail NCL counter chain: init/release, wavefront handshake,
// value capture, wavefront counting with programmable stall, illegal-code and timeout detection.
module ncl_counter_sequencer
  import ncl_seq_pkg::*;
#(
  parameter int DIGITS      = 32,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int INIT_CYCLES = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                init,
  input  logic                start,
  input  logic [CNT_W-1:0]    target,
  output logic                ring_init,
  input  logic [2*DIGITS-1:0] sum,
  output logic [DIGITS-1:0]   sum_comp,
  input  logic [1:0]          carry_top,
  output logic                carry_top_comp,
  output logic [DIGITS-1:0]   value,
  output logic                value_valid,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  output logic                busy,
  output logic                done,
  output logic                error
);
  localparam int CYC_MAX = (TIMEOUT > INIT_CYCLES) ? TIMEOUT : INIT_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  seq_state_t        state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  target_q, target_d, count_q, count_d;
  logic [DIGITS-1:0] value_q, value_d;
  logic vv_q, vv_d, ovf_q, ovf_d, err_q, err_d, comp_q, comp_d, ring_init_q, ring_init_d;

  logic              all_data, all_null, illegal, cur_carry1;
  logic [DIGITS-1:0] cur_value;

  dr_sync_classify #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC_STAGES)) u_cls (
    .clk       (clk),
    .init      (init),
    .sum       (sum),
    .carry_top (carry_top),
    .all_data  (all_data),
    .all_null  (all_null),
    .illegal   (illegal),
    .value     (cur_value),
    .carry1    (cur_carry1)
  );

  always_comb begin
    state_d  = state_q;
    cyc_d    = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);
    target_d = target_q;
    count_d  = count_q;
    value_d  = value_q;
    vv_d     = 1'b0;
    ovf_d    = ovf_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: if (start) state_d = RELEASE;
      RELEASE: begin
        if (illegal) state_d = ERROR;
        else if (cyc_q == CYC_W'(INIT_CYCLES - 1)) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (illegal) state_d = ERROR;
        else if (all_data) begin
          state_d = WAIT_NULL;
          value_d = cur_value;
          vv_d    = 1'b1;
          count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
          if (cur_carry1) ovf_d = 1'b1;
        end else if (cyc_q == CYC_W'(TIMEOUT - 1)) state_d = ERROR;
      end
      WAIT_NULL: begin
        if (illegal) state_d = ERROR;
        else if (all_null) state_d = (target_q != '0 && count_q == target_q) ? DONE : WAIT_DATA;
        else if (cyc_q == CYC_W'(TIMEOUT - 1)) state_d = ERROR;
      end
      DONE: begin
        if (start) state_d = RELEASE;
        else if (illegal) state_d = ERROR;
      end
      ERROR: if (start) state_d = RELEASE;
      default: state_d = IDLE;
    endcase

    // Every run restart clears the run-scoped status and re-latches the stall target.
    if (state_d == RELEASE && state_q != RELEASE) begin
      count_d  = '0;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
      target_d = target;
    end
    if (state_d == ERROR) err_d = 1'b1;
    if (state_d != state_q) cyc_d = '0;

    // Acks and ring_init are registered so the async fabric sees glitch-free levels.
    comp_d      = (state_d == WAIT_NULL) || (state_d == DONE);
    ring_init_d = (state_d == IDLE) || (state_d == RELEASE) || (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q     <= IDLE;
      cyc_q       <= '0;
      target_q    <= '0;
      count_q     <= '0;
      value_q     <= '0;
      vv_q        <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      comp_q      <= 1'b0;
      ring_init_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      target_q    <= target_d;
      count_q     <= count_d;
      value_q     <= value_d;
      vv_q        <= vv_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      comp_q      <= comp_d;
      ring_init_q <= ring_init_d;
    end
  end

  assign ring_init      = ring_init_q;
  assign sum_comp       = {DIGITS{comp_q}};
  assign carry_top_comp = comp_q;
  assign value          = value_q;
  assign value_valid    = vv_q;
  assign count          = count_q;
  assign overflow       = ovf_q;
  assign error          = err_q;
  assign busy           = (state_q == RELEASE) || (state_q == WAIT_DATA) || (state_q == WAIT_NULL);
  assign done           = (state_q == DONE);

endmodule
